// File: rtl/tx_uart_pkg.sv
// tx_uart_pkg
// Shared types and helpers for the buffered UART transmitter.
//   tx_state_t   : transmit FSM state encoding
//   PAR_*        : parity mode selectors for the PARITY parameter
//   frame_cycles : length of one complete frame in clk cycles
package tx_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int frame_cycles(input int data_bits, input int parity,
                                        input int stop_bits, input int cpb);
        return (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits) * cpb;
    endfunction

endpackage

// File: rtl/tx_uart_cfg_baud.sv
// uart_baud_gen
// Baud timer: down-counter that reloads to CLOCKS_PER_BAUD-1 whenever it reaches
// zero or is restarted, giving a tick on the last cycle of every baud.
//   clk       : system clock
//   i_reset_n : asynchronous active-low reset (counter clears to 0)
//   restart   : synchronous reload, aligns the baud to a new frame
//   o_tick    : high during the final cycle of each baud
module uart_baud_gen #(
    parameter int TIMER_BITS      = 16,
    parameter int CLOCKS_PER_BAUD = 868
) (
    input  logic clk,
    input  logic i_reset_n,
    input  logic restart,
    output logic o_tick
);

    localparam logic [TIMER_BITS-1:0] RELOAD = TIMER_BITS'(CLOCKS_PER_BAUD - 1);

    logic [TIMER_BITS-1:0] cnt_q;

    assign o_tick = (cnt_q == '0);

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else if (restart || o_tick) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/tx_uart_cfg.sv
// tx_uart_cfg
// Buffered UART transmitter. A one-entry holding register accepts words over a
// valid/ready handshake; the shifter sends them LSB first with optional parity
// and one or two stop bits. A word waiting at the end of the last stop bit is
// loaded straight into a new start bit, so back-to-back frames have no gap.
//   clk          : system clock
//   i_reset_n    : asynchronous active-low reset
//   i_valid      : i_data holds a word to send
//   i_data       : word to send, sampled on handshake
//   o_ready      : holding register empty (registered)
//   o_busy       : frame on the line or holding register full (registered)
//   uart_rxd_out : serial line, idle high (registered)
//
// state     | meaning
// ST_IDLE   | line high, waiting for a buffered word
// ST_START  | start bit (low)
// ST_DATA   | data bits, LSB first
// ST_PARITY | parity bit (skipped when PARITY = none)
// ST_STOP   | STOP_BITS bauds of high
module tx_uart_cfg
    import tx_uart_pkg::*;
#(
    parameter int DATA_BITS       = 8,
    parameter int TIMER_BITS      = 16,
    parameter int CLOCKS_PER_BAUD = 868,
    parameter int PARITY          = 0,
    parameter int STOP_BITS       = 1
) (
    input  logic                 clk,
    input  logic                 i_reset_n,
    input  logic                 i_valid,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_ready,
    output logic                 o_busy,
    output logic                 uart_rxd_out
);

    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("tx_uart_cfg: PARITY must be 0 (none), 1 (odd) or 2 (even)");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("tx_uart_cfg: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("tx_uart_cfg: STOP_BITS must be 1 or 2");
    end
    if (CLOCKS_PER_BAUD < 2) begin : g_bad_cpb
        $error("tx_uart_cfg: CLOCKS_PER_BAUD must be at least 2");
    end

    tx_state_t             state_q;
    logic [DATA_BITS-1:0]  hold_q;
    logic [DATA_BITS-1:0]  shreg_q;
    logic                  full_q;
    logic                  par_q;
    logic [3:0]            bit_idx_q;
    logic                  stop_idx_q;

    logic tick;
    logic accept;
    logic stop_last;
    logic stop_end;
    logic load;
    logic next_idle;

    assign accept    = i_valid && o_ready;
    assign stop_last = (stop_idx_q == 1'(STOP_BITS - 1));
    assign stop_end  = (state_q == ST_STOP) && tick && stop_last;
    assign load      = full_q && ((state_q == ST_IDLE) || stop_end);
    assign next_idle = ((state_q == ST_IDLE) && !full_q) || (stop_end && !full_q);

    uart_baud_gen #(
        .TIMER_BITS      (TIMER_BITS),
        .CLOCKS_PER_BAUD (CLOCKS_PER_BAUD)
    ) u_baud (
        .clk       (clk),
        .i_reset_n (i_reset_n),
        .restart   (load),
        .o_tick    (tick)
    );

    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            shreg_q      <= '0;
            full_q       <= 1'b0;
            par_q        <= 1'b0;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            o_ready      <= 1'b1;
            o_busy       <= 1'b0;
            uart_rxd_out <= 1'b1;
        end else begin
            // When the FSM is heading to idle the only way to stay busy is a
            // word arriving in this same cycle.
            o_busy <= !next_idle || accept;

            // Ready drops on the accepting edge itself and only comes back one
            // cycle after the holding register empties, so an accept can never
            // coincide with a load.
            if (accept) begin
                hold_q  <= i_data;
                full_q  <= 1'b1;
                o_ready <= 1'b0;
            end else begin
                o_ready <= !full_q;
            end

            if (load) begin
                full_q       <= 1'b0;
                shreg_q      <= hold_q;
                par_q        <= (PARITY == PAR_ODD) ? ~(^hold_q) : (^hold_q);
                bit_idx_q    <= '0;
                stop_idx_q   <= 1'b0;
                state_q      <= ST_START;
                uart_rxd_out <= 1'b0;
            end else if (tick) begin
                case (state_q)
                    ST_START: begin
                        state_q      <= ST_DATA;
                        uart_rxd_out <= shreg_q[0];
                    end
                    ST_DATA: begin
                        if (bit_idx_q == 4'(DATA_BITS - 1)) begin
                            if (PARITY != PAR_NONE) begin
                                state_q      <= ST_PARITY;
                                uart_rxd_out <= par_q;
                            end else begin
                                state_q      <= ST_STOP;
                                uart_rxd_out <= 1'b1;
                            end
                        end else begin
                            bit_idx_q    <= bit_idx_q + 4'd1;
                            shreg_q      <= shreg_q >> 1;
                            uart_rxd_out <= shreg_q[1];
                        end
                    end
                    ST_PARITY: begin
                        state_q      <= ST_STOP;
                        uart_rxd_out <= 1'b1;
                    end
                    ST_STOP: begin
                        if (stop_last) begin
                            state_q <= ST_IDLE;
                        end else begin
                            stop_idx_q <= 1'b1;
                        end
                        uart_rxd_out <= 1'b1;
                    end
                    default: begin
                        uart_rxd_out <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/tx_uart_cfg.md
# tx_uart_cfg

Parametrised, buffered UART transmitter: next-generation serial TX path for the board-level UART link. Accepts words over a valid/ready handshake into a one-entry holding register, then serialises LSB first with configurable data width, parity and stop bits. Back-to-back frames go out with no idle gap. Drives the FPGA's `uart_rxd_out` pin directly.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5..9.
- `TIMER_BITS`, 16: baud counter width; must hold `CLOCKS_PER_BAUD-1`.
- `CLOCKS_PER_BAUD`, 868: clk cycles per bit, ≥ 2.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even; 3 is illegal and fails elaboration.
- `STOP_BITS`, 1: 1 or 2.
- `clk` in 1: single clock, all logic on its rising edge.
- `i_reset_n` in 1: asynchronous, active-low reset.
- `i_valid` in 1: `i_data` holds a word to send.
- `i_data` in DATA_BITS: word to send; sampled only on handshake.
- `o_ready` in→out 1: holding register empty; handshake when `i_valid && o_ready` at a rising edge.
- `o_busy` out 1: a frame is on the line, or the holding register is full.
- `uart_rxd_out` out 1: serial line, idle high, registered.

## Operation
- Reset values: `uart_rxd_out`=1, `o_ready`=1, `o_busy`=0. FSM=IDLE, holding register empty, baud counter=0.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE, or → START for a back-to-back frame.
- Handshake writes the holding register and sets the full flag. `o_ready` = !full, registered. No accept while full.
- Shifter load: in IDLE with full=1, or at the last cycle of the final stop baud with full=1. The load clears full, moves the word into the shift register and enters START. The bit index counts 0..DATA_BITS-1 on the DATA edge and LSB goes first.
- Parity bit: even = XOR of the data bits; odd = its inverse. It is computed at load time. The PARITY state is skipped when `PARITY`=0.
- STOP lasts STOP_BITS bauds at line level 1. At STOP end with full=0, the FSM goes to IDLE.
- A handshake in the same cycle as a shifter load cannot occur, because `o_ready` is low while full.
- When `i_reset_n` is asserted mid-frame, the line goes high immediately. The buffered word is discarded and no partial frame resumes.

## Timing
- Handshake at edge k, idle shifter: FSM enters START at edge k+1 and `uart_rxd_out` is low from edge k+1. `o_ready` rises at edge k+2.
- Each bit holds exactly CLOCKS_PER_BAUD cycles. The counter reloads to CLOCKS_PER_BAUD-1 on every bit boundary and on load.
- Frame length = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLOCKS_PER_BAUD cycles.
- Back-to-back: the next start bit begins on the cycle after the final stop cycle, so there are zero idle cycles.
- `o_busy` is a registered OR of (FSM≠IDLE) and full. It falls on the edge where the FSM returns to IDLE with full=0.

## Structure
- `tx_uart_pkg` holds:
  - FSM state typedef (IDLE, START, DATA, PARITY, STOP);
  - parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - a frame-length function used by the bench.
- Sub-module `uart_baud_gen` (parameters TIMER_BITS, CLOCKS_PER_BAUD) provides:
  - a counter with a synchronous `restart` input;
  - a one-cycle `o_tick` at the end of each baud.
  - The TX FSM advances only on `o_tick` and asserts `restart` on load.

## Test plan
- CPB=4, 8N1, send 0x55 → line 0,1,0,1,0,1,0,1,0,1, each 4 cycles, then idle high. 40 cycles total, start low at handshake+1.
- CPB=4, 8E1, send 0x07 → parity bit 1, frame 44 cycles. With 8O1, same data → parity bit 0.
- CPB=4, 8N1, `i_valid` held with 0xA5 then 0x3C → `o_ready` low from handshake+1 until the second word loads. The second start bit directly follows the first stop bit, with no gap.
- CPB=3, DATA_BITS=5, STOP_BITS=2, send 0x1F → 0, five 1s, two stop 1s. Frame 24 cycles; `o_busy` falls at cycle 24 after the start edge.
- Assert `i_reset_n`=0 mid-DATA with a word buffered → `uart_rxd_out`=1 and `o_ready`=1 immediately. After release, no output until a new handshake.
- `i_valid`=1 while `o_ready`=0 with changing `i_data` → buffered word unchanged and transmitted as first accepted.
